// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage 72/64 SECDED decoder with valid/ready on both sides.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_data[71:0] = {check, data};
//   out_valid/out_ready/out_data/out_ce/out_ue/out_pos/out_syn; cnt_clr, ce_cnt, ue_cnt.

package SECDED_ECC_pkg;

  // Data column i is the i-th 8-bit value, in ascending order, with odd weight >= 3.
  // Odd weights make every double error an even-weight syndrome that no column matches.
  function automatic logic [511:0] gen_cols();
    logic [511:0] t;
    logic [7:0]   b;
    int           n;
    int           w;
    t = '0;
    n = 0;
    for (int v = 0; v < 256; v++) begin
      b = v[7:0];
      w = $countones(b);
      if (w >= 3 && (w % 2) == 1 && n < 64) begin
        t[n*8 +: 8] = b;
        n++;
      end
    end
    return t;
  endfunction

  localparam logic [511:0] COL_TAB = gen_cols();

  function automatic logic [7:0] mega_xor(input logic [63:0] d);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) begin
      if (d[i]) s = s ^ COL_TAB[i*8 +: 8];
    end
    return s;
  endfunction

endpackage

module secded_decoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_ce,
  output logic             out_ue,
  output logic [6:0]       out_pos,
  output logic [7:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] ue_cnt
);
  import SECDED_ECC_pkg::*;

  // Columns 64..71 are the unit vectors of the check bits.
  localparam logic [575:0] COL72 = {
    8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01,
    COL_TAB
  };

  logic             s1_valid_q, s1_valid_d;
  logic [71:0]      s1_cw_q, s1_cw_d;
  logic [7:0]       s1_syn_q, s1_syn_d;

  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_ce_q, out_ce_d;
  logic             out_ue_q, out_ue_d;
  logic [6:0]       out_pos_q, out_pos_d;
  logic [7:0]       out_syn_q, out_syn_d;

  logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0] ue_cnt_q, ue_cnt_d;

  logic             s2_load;
  logic             s1_load;
  logic             out_fire;
  logic [6:0]       hit_cnt;
  logic [6:0]       hit_pos;
  logic             is_ce;
  logic             is_ue;
  logic [63:0]      fix_data;

  // Classification of the word sitting in S1.
  always_comb begin
    hit_cnt = '0;
    hit_pos = '0;
    for (int k = 0; k < 72; k++) begin
      if (s1_syn_q == COL72[k*8 +: 8]) begin
        hit_cnt = hit_cnt + 7'd1;
        hit_pos = 7'(k);
      end
    end
    is_ce    = (hit_cnt == 7'd1);
    is_ue    = (s1_syn_q != 8'h00) && !is_ce;
    fix_data = s1_cw_q[63:0];
    if (is_ce && !hit_pos[6]) begin
      fix_data[hit_pos[5:0]] = ~fix_data[hit_pos[5:0]];
    end
  end

  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    out_fire = out_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d  = in_data;
        s1_syn_d = in_data[71:64] ^ mega_xor(in_data[63:0]);
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ce_d    = out_ce_q;
    out_ue_d    = out_ue_q;
    out_pos_d   = out_pos_q;
    out_syn_d   = out_syn_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = fix_data;
        out_ce_d   = is_ce;
        out_ue_d   = is_ue;
        out_pos_d  = is_ce ? hit_pos : 7'd0;
        out_syn_d  = s1_syn_q;
      end
    end

    // Clear wins over a same-cycle increment.
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (out_fire) begin
      if (out_ce_q && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (out_ue_q && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ce_q    <= 1'b0;
      out_ue_q    <= 1'b0;
      out_pos_q   <= '0;
      out_syn_q   <= '0;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ce_q    <= out_ce_d;
      out_ue_q    <= out_ue_d;
      out_pos_q   <= out_pos_d;
      out_syn_q   <= out_syn_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ce    = out_ce_q;
  assign out_ue    = out_ue_q;
  assign out_pos   = out_pos_q;
  assign out_syn   = out_syn_q;
  assign ce_cnt    = ce_cnt_q;
  assign ue_cnt    = ue_cnt_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// tb_secded_decoder_pipe: directed vectors, scoreboard queue, decoupled output monitor.
// Small counter width so saturation is reachable with a few words.

module tb_secded_decoder_pipe;
  import SECDED_ECC_pkg::*;

  localparam int CW = 3;

  typedef struct packed {
    logic [63:0] d;
    logic        ce;
    logic        ue;
    logic [6:0]  pos;
    logic [7:0]  syn;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [71:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic          out_ce;
  logic          out_ue;
  logic [6:0]    out_pos;
  logic [7:0]    out_syn;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] ce_cnt;
  logic [CW-1:0] ue_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  secded_decoder_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue),
    .out_pos(out_pos), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] enc(input logic [63:0] d);
    return {mega_xor(d), d};
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input logic ce, input logic ue,
                              input logic [6:0] pos, input logic [7:0] syn);
    exp_t e;
    e = '{d: d, ce: ce, ue: ue, pos: pos, syn: syn};
    return e;
  endfunction

  // Monitor: samples 1 time unit before each rising edge.
  initial begin : mon
    logic [95:0] cur;
    logic [95:0] prev;
    logic        held;
    exp_t        e;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #4;
      cur = {14'd0, out_valid, out_data, out_ce, out_ue, out_pos, out_syn};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) chk("held_stable", cur, prev);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_out got %h want none", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_word", {15'd0, e}, {15'd0, out_data, out_ce, out_ue, out_pos, out_syn});
          end
        end
        held = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  // Drive at negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [71:0] cw, input exp_t e, input bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = cw;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 want 1");
    end else if (push) begin
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d want 0", sb.size());
    end
    @(negedge clk);
  endtask

  localparam logic [63:0] D  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D2 = 64'hFFFF_0000_AAAA_5555;
  localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;

  initial begin : drv
    logic [71:0] c;
    longint      t0;
    int          n;
    c = enc(D);

    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_fields", {out_data, out_ce, out_ue, out_pos, out_syn}, 0);
    chk("rst_cnts", {ce_cnt, ue_cnt}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Clean word and latency.
    send(c, mk(D, 0, 0, 0, 0), 1);
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    chk("lat_on_time", {out_valid, out_data}, {1'b1, D});
    drain();
    chk("cnt_clean", {ce_cnt, ue_cnt}, 0);

    send(c ^ (72'd1 << 5), mk(D, 1, 0, 5, 8'h15), 1);
    drain();
    chk("ce_cnt_1", ce_cnt, 1);

    send(c ^ (72'd1 << 66), mk(D, 1, 0, 66, 8'h04), 1);
    drain();
    chk("ce_cnt_2", ce_cnt, 2);

    send(c ^ 72'd3, mk(D ^ 64'd3, 0, 1, 0, 8'h0C), 1);
    drain();
    chk("ue_cnt_1", {ce_cnt, ue_cnt}, {3'd2, 3'd1});

    send(c ^ (72'd1 << 64) ^ 72'd1, mk(D ^ 64'd1, 0, 1, 0, 8'h06), 1);
    drain();
    chk("ue_cnt_2", ue_cnt, 2);

    // Back-to-back burst with edge-position single errors.
    t0 = $time;
    send(enc(D2) ^ (72'd1 << 63), mk(D2, 1, 0, 63, 8'h8F), 1);
    send(enc(D3) ^ (72'd1 << 71), mk(D3, 1, 0, 71, 8'h80), 1);
    send(enc(D3), mk(D3, 0, 0, 0, 0), 1);
    chk("burst_rate", 96'($time - t0), 30);
    drain();
    chk("ce_cnt_4", ce_cnt, 4);

    // Backpressure: A and B fill the pipe, C is held off.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = enc(D);
    #1;
    chk("bp_rdy_a", in_ready, 1);
    sb.push_back(mk(D, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    in_data = enc(D2);
    #1;
    chk("bp_rdy_b", in_ready, 1);
    sb.push_back(mk(D2, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    in_data = enc(D3);
    #1;
    chk("bp_full", in_ready, 0);
    chk("bp_hold_a", {out_valid, out_data}, {1'b1, D});
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("bp_still_full", {in_ready, out_data}, {1'b0, D});
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release", in_ready, 1);
    sb.push_back(mk(D3, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_seq_b", out_valid, 1);
    @(negedge clk);
    chk("bp_seq_c", out_valid, 1);
    drain();

    // Saturation at 3'b111.
    repeat (3) begin
      send(c ^ (72'd1 << 5), mk(D, 1, 0, 5, 8'h15), 1);
      drain();
    end
    chk("ce_sat_reach", ce_cnt, 7);
    send(c ^ (72'd1 << 5), mk(D, 1, 0, 5, 8'h15), 1);
    drain();
    chk("ce_sat_hold", ce_cnt, 7);

    // Clear in the same cycle as a CE handshake.
    out_ready = 1'b0;
    send(c ^ (72'd1 << 5), mk(D, 1, 0, 5, 8'h15), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clr_wait", out_valid, 1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_prio", {ce_cnt, ue_cnt}, 0);

    send(c ^ 72'd3, mk(D ^ 64'd3, 0, 1, 0, 8'h0C), 1);
    drain();
    chk("ue_after_clr", ue_cnt, 1);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(c ^ (72'd1 << 5), mk(D, 1, 0, 5, 8'h15), 0);
    send(c, mk(D, 0, 0, 0, 0), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fields", {out_data, out_ce, out_ue, out_pos, out_syn}, 0);
    chk("mid_rst_cnts", {ce_cnt, ue_cnt}, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_stale", out_valid, 0);

    send(enc(D2), mk(D2, 0, 0, 0, 0), 1);
    drain();
    chk("post_rst_cnts", {ce_cnt, ue_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
